// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: instruction/register field layout, reset and NOP
// constants, fetch-stage state encoding and small address helpers.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam int REG_W   = 5;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;

  localparam logic [INSTR_W-1:0] MIPS_RESET_PC  = 32'h0040_0000;
  localparam logic [INSTR_W-1:0] MIPS_NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_IDLE    = 2'd0,
    FS_FETCH   = 2'd1,
    FS_DISCARD = 2'd2,
    FS_FULL    = 2'd3
  } fetch_state_e;

  function automatic logic [INSTR_W-1:0] pc_plus4(input logic [INSTR_W-1:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [INSTR_W-1:0] align_pc(input logic [INSTR_W-1:0] pc);
    return {pc[INSTR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// Pipeline register between fetch and decode: load, flush-to-bubble or hold,
// with rs/rt fields exposed for the hazard unit.
module ifid_reg import mips_pkg::*; #(
  parameter logic [INSTR_W-1:0] NOP_INSTR = MIPS_NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [INSTR_W-1:0] in_pc4,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [INSTR_W-1:0] pc4,
  output logic [REG_W-1:0]   rs,
  output logic [REG_W-1:0]   rt
);

  logic               valid_q, valid_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [INSTR_W-1:0] pc4_q, pc4_d;

  // Flush wins over load so a redirect always leaves a bubble behind.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (flush) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      pc4_d   = '0;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = in_instr;
      pc4_d   = in_pc4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  assign valid = valid_q;
  assign instr = instr_q;
  assign pc4   = pc4_q;
  assign rs    = instr_q[RS_MSB:RS_LSB];
  assign rt    = instr_q[RT_MSB:RT_LSB];

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC, imem req/ack handshake, one-entry skid buffer, IF/ID.
// Define IF_PERF_CNT_EN to add fetch/bubble/flush performance counters.
module if_stage import mips_pkg::*; #(
  parameter logic [INSTR_W-1:0] RESET_PC  = MIPS_RESET_PC,
  parameter logic [INSTR_W-1:0] NOP_INSTR = MIPS_NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [INSTR_W-1:0] redirect_pc,
  output logic               imem_req,
  output logic [INSTR_W-1:0] imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]        perf_fetch_cnt,
  output logic [31:0]        perf_bubble_cnt,
  output logic [31:0]        perf_flush_cnt,
`endif
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [INSTR_W-1:0] ifid_pc4,
  output logic [REG_W-1:0]   ifid_rs,
  output logic [REG_W-1:0]   ifid_rt
);

  fetch_state_e       state_q, state_d;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] addr_q, addr_d;
  logic [INSTR_W-1:0] buf_instr_q, buf_instr_d;
  logic [INSTR_W-1:0] buf_pc4_q, buf_pc4_d;

  logic               ifid_load;
  logic               ifid_flush;
  logic [INSTR_W-1:0] ifid_instr_in;
  logic [INSTR_W-1:0] ifid_pc4_in;
  logic [INSTR_W-1:0] ack_pc4;

  assign ack_pc4   = pc_plus4(addr_q);
  assign imem_req  = (state_q == FS_FETCH) || (state_q == FS_DISCARD);
  assign imem_addr = addr_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    addr_d        = addr_q;
    buf_instr_d   = buf_instr_q;
    buf_pc4_d     = buf_pc4_q;
    ifid_load     = 1'b0;
    ifid_flush    = 1'b0;
    ifid_instr_in = imem_rdata;
    ifid_pc4_in   = ack_pc4;

    case (state_q)
      FS_IDLE: begin
        state_d    = FS_FETCH;
        ifid_flush = !stall;
      end
      FS_FETCH: begin
        if (imem_ack) begin
          pc_d = ack_pc4;
          // A stalled decode cannot take the word, so park it in the skid buffer.
          if (stall) begin
            buf_instr_d = imem_rdata;
            buf_pc4_d   = ack_pc4;
            state_d     = FS_FULL;
          end else begin
            ifid_load = 1'b1;
          end
        end else begin
          ifid_flush = !stall;
        end
      end
      FS_DISCARD: begin
        if (imem_ack) state_d = FS_FETCH;
        ifid_flush = !stall;
      end
      FS_FULL: begin
        if (!stall) begin
          ifid_load     = 1'b1;
          ifid_instr_in = buf_instr_q;
          ifid_pc4_in   = buf_pc4_q;
          state_d       = FS_FETCH;
        end
      end
      default: state_d = FS_IDLE;
    endcase

    // An outstanding request cannot be withdrawn, so its data is dropped in DISCARD.
    if (redirect) begin
      pc_d       = align_pc(redirect_pc);
      ifid_load  = 1'b0;
      ifid_flush = 1'b1;
      state_d    = (imem_req && !imem_ack) ? FS_DISCARD : FS_FETCH;
    end

    // The address register only moves when no request is pending on the bus.
    if (!imem_req || imem_ack) addr_d = pc_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FS_IDLE;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      buf_instr_q <= NOP_INSTR;
      buf_pc4_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
    end
  end

  ifid_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ifid_load),
    .flush    (ifid_flush),
    .in_instr (ifid_instr_in),
    .in_pc4   (ifid_pc4_in),
    .valid    (ifid_valid),
    .instr    (ifid_instr),
    .pc4      (ifid_pc4),
    .rs       (ifid_rs),
    .rt       (ifid_rt)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q + {31'd0, ifid_load};
    bubble_cnt_d = bubble_cnt_q + {31'd0, ifid_flush && !stall && !redirect};
    flush_cnt_d  = flush_cnt_q + {31'd0, redirect};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign perf_fetch_cnt  = fetch_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
  assign perf_flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed fetch/stall/redirect/reset scenarios plus a randomized run,
// with a wait-state memory model and an in-order program-stream scoreboard.
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic [4:0]  ifid_rs;
  logic [4:0]  ifid_rt;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          nwait;
  int          wcnt;
  bit          req_seen;
  logic [31:0] held_addr;
  logic [31:0] exp_pc;
  int          consumed;

  if_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .ifid_valid  (ifid_valid),
    .ifid_instr  (ifid_instr),
    .ifid_pc4    (ifid_pc4),
    .ifid_rs     (ifid_rs),
    .ifid_rt     (ifid_rt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   {31'd0, imem_req}, 32'd0);
    chk({tag, "_addr"},  imem_addr, RST_PC);
    chk({tag, "_valid"}, {31'd0, ifid_valid}, 32'd0);
    chk({tag, "_instr"}, ifid_instr, NOP);
    chk({tag, "_pc4"},   ifid_pc4, 32'd0);
  endtask

  task automatic do_reset(input int w);
    @(negedge clk);
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    nwait       = w;
    wcnt        = 0;
    req_seen    = 1'b0;
    exp_pc      = RST_PC;
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: memory response, protocol checks and in-order delivery scoreboard.
  task automatic cycle(input logic s, input logic r, input logic [31:0] tgt);
    logic ack_now;
    @(negedge clk);
    if (req_seen) begin
      chk("req_held", {31'd0, imem_req}, 32'd1);
      chk("addr_stable", imem_addr, held_addr);
    end
    ack_now     = imem_req && (wcnt >= nwait);
    stall       = s;
    redirect    = r;
    redirect_pc = tgt;
    imem_ack    = ack_now;
    imem_rdata  = ack_now ? mem_word(imem_addr) : $urandom();
    if (imem_req && !ack_now) begin
      req_seen  = 1'b1;
      held_addr = imem_addr;
      wcnt++;
    end else begin
      req_seen = 1'b0;
      wcnt     = 0;
    end
    if (ifid_valid && !s) begin
      chk("sb_pc4", ifid_pc4, exp_pc + 32'd4);
      chk("sb_instr", ifid_instr, mem_word(exp_pc));
      consumed++;
      exp_pc = exp_pc + 32'd4;
    end
    if (r) exp_pc = {tgt[31:2], 2'b00};
  endtask

  initial begin
    logic [31:0] w;
    int          base;
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    consumed    = 0;

    // Zero-wait memory: back-to-back fetch.
    do_reset(0);
    cycle(0, 0, 0);
    chk("zw_req1", {31'd0, imem_req}, 32'd1);
    chk("zw_addr1", imem_addr, 32'h0040_0000);
    chk("zw_valid1", {31'd0, ifid_valid}, 32'd0);
    cycle(0, 0, 0);
    w = mem_word(32'h0040_0000);
    chk("zw_addr2", imem_addr, 32'h0040_0004);
    chk("zw_valid2", {31'd0, ifid_valid}, 32'd1);
    chk("zw_pc4_2", ifid_pc4, 32'h0040_0004);
    chk("zw_instr2", ifid_instr, w);
    chk("zw_rs2", {27'd0, ifid_rs}, {27'd0, w[25:21]});
    chk("zw_rt2", {27'd0, ifid_rt}, {27'd0, w[20:16]});
    cycle(0, 0, 0);
    chk("zw_addr3", imem_addr, 32'h0040_0008);
    chk("zw_pc4_3", ifid_pc4, 32'h0040_0008);

    // Two wait states: one instruction every third cycle, bubbles between.
    do_reset(2);
    for (int k = 1; k <= 12; k++) begin
      cycle(0, 0, 0);
      if (k >= 4) begin
        chk("ws2_valid", {31'd0, ifid_valid}, {31'd0, ((k - 4) % 3) == 0});
        if (((k - 4) % 3) == 0) chk("ws2_pc4", ifid_pc4, RST_PC + 32'(4 * ((k - 4) / 3 + 1)));
        else chk("ws2_bubble", ifid_instr, NOP);
      end
    end

    // Stall for three cycles while an ack arrives: skid buffer, no new request.
    do_reset(0);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    chk("st_pc4_a", ifid_pc4, 32'h0040_0004);
    cycle(1, 0, 0);
    chk("st_req_b", {31'd0, imem_req}, 32'd0);
    chk("st_pc4_b", ifid_pc4, 32'h0040_0004);
    cycle(1, 0, 0);
    chk("st_req_c", {31'd0, imem_req}, 32'd0);
    chk("st_valid_c", {31'd0, ifid_valid}, 32'd1);
    cycle(0, 0, 0);
    chk("st_pc4_d", ifid_pc4, 32'h0040_0004);
    cycle(0, 0, 0);
    chk("st_pc4_e", ifid_pc4, 32'h0040_0008);
    chk("st_addr_e", imem_addr, 32'h0040_0008);
    cycle(0, 0, 0);
    chk("st_pc4_f", ifid_pc4, 32'h0040_000C);

    // Redirect during an outstanding 3-wait fetch of 0x00400010.
    do_reset(3);
    for (int k = 1; k <= 25; k++) begin
      cycle(0, k == 17, 32'h0040_0100);
      if (k == 17) chk("rd_addr_pre", imem_addr, 32'h0040_0010);
      if (k >= 18 && k <= 20) begin
        chk("rd_addr_hold", imem_addr, 32'h0040_0010);
        chk("rd_req_hold", {31'd0, imem_req}, 32'd1);
        chk("rd_bubble", {31'd0, ifid_valid}, 32'd0);
      end
      if (k == 21) begin
        chk("rd_addr_new", imem_addr, 32'h0040_0100);
        chk("rd_valid_new", {31'd0, ifid_valid}, 32'd0);
      end
      if (k == 25) chk("rd_pc4_tgt", ifid_pc4, 32'h0040_0104);
    end

    // Redirect together with stall while the skid buffer is full.
    do_reset(0);
    cycle(0, 0, 0);
    cycle(1, 0, 0);
    cycle(1, 1, 32'h0040_0200);
    chk("fl_req_full", {31'd0, imem_req}, 32'd0);
    cycle(0, 0, 0);
    chk("fl_valid", {31'd0, ifid_valid}, 32'd0);
    chk("fl_instr", ifid_instr, NOP);
    chk("fl_addr", imem_addr, 32'h0040_0200);
    cycle(0, 0, 0);
    chk("fl_pc4", ifid_pc4, 32'h0040_0204);

    // PC wraps modulo 2^32 and redirect targets are word aligned.
    do_reset(0);
    cycle(0, 0, 0);
    cycle(0, 1, 32'hFFFF_FFFF);
    cycle(0, 0, 0);
    chk("wr_addr_top", imem_addr, 32'hFFFF_FFFC);
    chk("wr_valid_top", {31'd0, ifid_valid}, 32'd0);
    cycle(0, 0, 0);
    chk("wr_pc4_zero", ifid_pc4, 32'h0000_0000);
    chk("wr_addr_zero", imem_addr, 32'h0000_0000);
    cycle(0, 1, 32'h0040_0123);
    chk("wr_addr_four", imem_addr, 32'h0000_0004);
    cycle(0, 0, 0);
    chk("al_addr", imem_addr, 32'h0040_0120);

    // Asynchronous reset in the middle of a request, between clock edges.
    do_reset(0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("ar_valid_pre", {31'd0, ifid_valid}, 32'd1);
    chk("ar_req_pre", {31'd0, imem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_rst");

    // Randomized stalls, wait states and redirects against the stream scoreboard.
    do_reset(1);
    base = consumed;
    for (int k = 0; k < 600; k++) begin
      if ((k % 16) == 0) nwait = $urandom_range(0, 3);
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
            32'h0040_0000 | ($urandom() & 32'h0000_FFFF));
    end
    chk("rand_progress", {31'd0, (consumed - base) >= 60}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: PC register, instruction-memory request/acknowledge handshake, one-entry skid buffer, and IF/ID pipeline register.
- Consumes the hazard unit's stall and the ID-stage branch/jump redirect.
- Drives the IF/ID rs/rt fields to the hazard unit and the instruction/PC+4 to decode.

Parameters:
RESET_PC, 32'h0040_0000, first fetch address after reset (MIPS text base)
NOP_INSTR, 32'h0000_0000, instruction word loaded into IF/ID on a bubble or flush (sll $0,$0,0)

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
stall  input  1  from hazard unit; 1 = hold IF/ID and PC (load-use)
redirect  input  1  from ID; 1 = branch taken or jump, fetch from redirect_pc
redirect_pc  input  32  branch/jump target, word aligned
imem_req  output  1  fetch request; held high until imem_ack
imem_addr  output  32  fetch address; stable while imem_req=1
imem_ack  input  1  single-cycle ack; imem_rdata valid same cycle
imem_rdata  input  32  fetched instruction
ifid_valid  output  1  IF/ID holds a real instruction
ifid_instr  output  32  IF/ID instruction
ifid_pc4  output  32  IF/ID address+4
ifid_rs  output  5  ifid_instr[25:21], to hazard unit
ifid_rt  output  5  ifid_instr[20:16], to hazard unit

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc4=0, buffer empty.
- States: IDLE, FETCH (req=1, data wanted), DISCARD (req=1, data dropped), FULL (req=0, buffer holds one instruction).
- IDLE: one cycle after reset release; imem_addr<=pc, go FETCH.
- Request rule: once imem_req rises it is never withdrawn and imem_addr never changes until imem_ack. After an ack in FETCH with no stall/redirect, the next request is issued the following cycle at pc+4 (back-to-back; zero-wait memory gives one instruction per cycle).
- FETCH, ack, stall=0, redirect=0: IF/ID<=(rdata, imem_addr+4, valid=1); pc<=imem_addr+4; stay FETCH.
- FETCH, ack, stall=1, redirect=0: buffer<=(rdata, imem_addr+4); pc<=imem_addr+4; go FULL; IF/ID holds.
- FETCH, no ack, stall=0: IF/ID<=bubble (valid=0, NOP_INSTR).
- FULL, stall=0: IF/ID<=buffer; buffer cleared; go FETCH at pc.
- FULL, stall=1: hold everything.
- Redirect:
  - Priority over stall.
  - IF/ID<=bubble; pc<=redirect_pc.
  - FETCH without ack -> DISCARD.
  - FETCH with ack same cycle -> data dropped; go FETCH at redirect_pc.
  - FULL -> buffer dropped; go FETCH.
  - DISCARD -> pc updated to the newest target; stay DISCARD.
- DISCARD: on ack, drop data and go FETCH at pc; IF/ID gets a bubble each non-stalled cycle.
- Stall with IF/ID and buffer both full: no new request issued. No instruction is ever lost or duplicated.
- Arithmetic: PC+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0. redirect_pc[1:0] is ignored, forced to 00.
- rst_n asserted mid-request: abandon immediately. The memory tolerates req dropping on reset only.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetch_cnt[31:0], perf_bubble_cnt[31:0], perf_flush_cnt[31:0], reset to 0, wrapping.
  - Increments: instructions loaded valid into IF/ID; bubble cycles loaded with stall=0 and redirect=0; redirect cycles.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package mips_pkg: NOP_INSTR, RESET_PC, fetch state enum, RS/RT field bit positions, instruction-word width.
- Sub-module ifid_reg: IF/ID register with load/flush/hold controls and rs/rt extraction, reused by the ID/EX-style registers.

Test Plan:
- Reset release, zero-wait memory (ack same cycle as req): imem_addr 0x00400000, 0x00400004, 0x00400008 on consecutive cycles; ifid_valid=1 from 2nd cycle after release; ifid_pc4=0x00400004 first.
- Memory with 2 wait states: one valid IF/ID instruction every 3 cycles, bubbles (valid=0, instr=0) between; imem_addr stable while req=1.
- stall=1 for 3 cycles while ack arrives: instruction captured in buffer, no new req, IF/ID unchanged; after stall drops, buffered instr appears next cycle, then fetch resumes at pc+4 with no gap or duplicate.
- redirect to 0x00400100 while a 3-wait fetch of 0x00400010 is outstanding: req/addr held until ack, data discarded, next req at 0x00400100; IF/ID bubbles meanwhile.
- redirect and stall asserted together in FULL: buffer and IF/ID flushed (valid=0), next fetch at redirect_pc.
- Async reset mid-request: all outputs return to reset values in the same cycle, no clock edge needed.
